// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        REM  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit: one shift-add or restoring-divide step per clock,
// with a one-cycle done pulse and register-file write-back address/enable.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [AW-1:0]    wa_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [AW-1:0]    wa_out,
    output logic             we_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e            state, state_next;
    logic [CW-1:0]     cnt;
    op_e               op_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [AW-1:0]     wa_q;

    logic              load;
    logic              step;
    logic              finish;
    logic              busy_d;
    logic              done_d;
    logic              is_mul;
    logic [2*WIDTH-1:0] step_val;
    logic [WIDTH-1:0]  hi_nx;
    logic [WIDTH-1:0]  lo_nx;
    logic [WIDTH-1:0]  result_nx;

    // Shift-add step: hi/lo form the 2*WIDTH accumulator, lo's LSB selects the add.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                     input logic [WIDTH-1:0] lo,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        return {sum, lo[WIDTH-1:1]};
    endfunction

    // Restoring divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                     input logic [WIDTH-1:0] lo,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        if (diff[WIDTH])
            return {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        else
            return {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_next = DONE;
            DONE: state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy_d = (state_next == RUN);
        done_d = (state_next == DONE);
        case (state)
            IDLE: load = start;
            RUN: begin
                step   = 1'b1;
                finish = (cnt == CW'(WIDTH - 1));
            end
            DONE: load = start;
            default: ;
        endcase
    end

    assign is_mul   = (op_q == MUL) || (op_q == MULH);
    assign step_val = is_mul ? mul_step(hi_q, lo_q, b_q) : div_step(hi_q, lo_q, b_q);
    assign hi_nx    = step_val[2*WIDTH-1:WIDTH];
    assign lo_nx    = step_val[WIDTH-1:0];

    always_comb begin
        case (op_q)
            MULH:    result_nx = hi_nx;
            REM:     result_nx = hi_nx;
            default: result_nx = lo_nx;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= MUL;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            wa_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            wa_out <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (load) begin
                cnt  <= '0;
                op_q <= op_e'(op);
                b_q  <= src_b;
                hi_q <= '0;
                lo_q <= src_a;
                wa_q <= wa_in;
            end else if (step) begin
                cnt  <= cnt + CW'(1);
                hi_q <= hi_nx;
                lo_q <= lo_nx;
            end
            if (finish) begin
                result <= result_nx;
                wa_out <= wa_q;
            end
        end
    end

    assign we_out = done & (|wa_out);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized operations against
// an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [AW-1:0] wa_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [AW-1:0] wa_out;
    logic          we_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W), .AW(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .wa_in  (wa_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa_out (wa_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int unsigned p;
        p = 32'(a) * 32'(b);
        case (o)
            2'd0:    return W'(p);
            2'd1:    return W'(p >> W);
            2'd2:    return (b == 0) ? {W{1'b1}} : W'(32'(a) / 32'(b));
            default: return (b == 0) ? a : W'(32'(a) % 32'(b));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for its done pulse; lat = -1 if none arrived.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] wa, output logic [W-1:0] res,
                         output logic [AW-1:0] wao, output logic we, output int lat);
        op = o; src_a = a; src_b = b; wa_in = wa; start = 1'b1;
        lat = -1; res = '0; wao = '0; we = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) begin
                start = 1'b0;
                op    = 2'($urandom);
                src_a = W'($urandom);
                src_b = W'($urandom);
                wa_in = AW'($urandom);
            end
            if (done) begin
                lat = i; res = result; wao = wa_out; we = we_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 2'd0; src_a = 8'd5; src_b = 8'd5; wa_in = 4'd1;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we_out); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
        checks++; if (wa_out !== 4'h0) begin errors++; $display("FAIL reset_wa got %h want 0", wa_out); end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [1:0]    t_op [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [W-1:0]  t_a  [7] = '{8'd13, 8'd200, 8'd200, 8'd100, 8'd100, 8'h55, 8'h55};
        logic [W-1:0]  t_b  [7] = '{8'd11, 8'd200, 8'd200, 8'd7, 8'd7, 8'h00, 8'h00};
        logic [AW-1:0] t_wa [7] = '{4'd3, 4'd5, 4'd5, 4'd1, 4'd2, 4'd6, 4'd7};
        logic [W-1:0]  t_r  [7] = '{8'h8F, 8'h9C, 8'h40, 8'h0E, 8'h02, 8'hFF, 8'h55};
        logic [W-1:0]  res;
        logic [AW-1:0] wao;
        logic          we;
        int            lat;
        for (int k = 0; k < 7; k++) begin
            do_op(t_op[k], t_a[k], t_b[k], t_wa[k], res, wao, we, lat);
            checks++; if (res !== t_r[k]) begin errors++; $display("FAIL dir%0d_result got %h want %h", k, res, t_r[k]); end
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, W + 1); end
            checks++; if (wao !== t_wa[k]) begin errors++; $display("FAIL dir%0d_wa got %h want %h", k, wao, t_wa[k]); end
            checks++; if (we !== 1'b1) begin errors++; $display("FAIL dir%0d_we got %b want 1", k, we); end
        end
        tick();
        checks++; if (result !== 8'h55) begin errors++; $display("FAIL hold_result got %h want 55", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_random();
        logic [1:0]    o;
        logic [W-1:0]  a, b, res, exp;
        logic [AW-1:0] wa, wao;
        logic          we;
        int            lat;
        for (int k = 0; k < 40; k++) begin
            o  = 2'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            wa = AW'($urandom);
            exp = model(o, a, b);
            do_op(o, a, b, wa, res, wao, we, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d op%0d %h,%h result got %h want %h", k, o, a, b, res, exp); end
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, W + 1); end
            checks++; if (we !== (wa != 0)) begin errors++; $display("FAIL rnd%0d_we got %b want %b", k, we, (wa != 0)); end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_start_in_run();
        int           ndone = 0;
        int           lat = -1;
        logic [W-1:0] res = '0;
        op = 2'd0; src_a = 8'd13; src_b = 8'd11; wa_in = 4'd3; start = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            start = 1'b0;
            if (i == 3 || i == 5) begin
                start = 1'b1; op = 2'd2; src_a = W'($urandom); src_b = W'($urandom); wa_in = 4'd9;
            end
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = i; res = result; end
            end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL run_ignore_dones got %0d want 1", ndone); end
        checks++; if (res !== 8'h8F) begin errors++; $display("FAIL run_ignore_result got %h want 8f", res); end
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL run_ignore_latency got %0d want %0d", lat, W + 1); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, r1, r2;
        logic         we2 = 1'b1;
        logic         busy_after = 1'b0;
        logic         busy_in_done = 1'b1;
        int           d1 = -1;
        int           d2 = -1;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom_range(1, 255));
        r1 = '0; r2 = '0;
        op = 2'd1; src_a = a1; src_b = b1; wa_in = 4'd9; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) begin op = 2'd2; src_a = a2; src_b = b2; wa_in = 4'd0; end
            if (d1 > 0 && i == d1 + 1) busy_after = busy;
            if (done) begin
                if (d1 < 0) begin
                    d1 = i; r1 = result; busy_in_done = busy;
                end else begin
                    d2 = i; r2 = result; we2 = we_out; start = 1'b0;
                    break;
                end
            end
        end
        checks++; if (r1 !== model(2'd1, a1, b1)) begin errors++; $display("FAIL b2b_first got %h want %h", r1, model(2'd1, a1, b1)); end
        checks++; if (r2 !== model(2'd2, a2, b2)) begin errors++; $display("FAIL b2b_second got %h want %h", r2, model(2'd2, a2, b2)); end
        checks++; if (d2 - d1 !== W + 1) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", d2 - d1, W + 1); end
        checks++; if (busy_in_done !== 1'b0) begin errors++; $display("FAIL b2b_busy_done got %b want 0", busy_in_done); end
        checks++; if (busy_after !== 1'b1) begin errors++; $display("FAIL b2b_no_idle got %b want 1", busy_after); end
        checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL b2b_we_zero got %b want 0", we2); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic          seen = 1'b0;
        logic [W-1:0]  res;
        logic [AW-1:0] wao;
        logic          we;
        int            lat;
        op = 2'd0; src_a = 8'hFF; src_b = 8'hFF; wa_in = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result got %h want 00", result); end
        checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", we_out); end
        for (int i = 0; i < 12; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", seen); end
        do_op(2'd0, 8'd2, 8'd3, 4'd2, res, wao, we, lat);
        checks++; if (res !== 8'h06) begin errors++; $display("FAIL post_reset_result got %h want 06", res); end
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", lat, W + 1); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL post_reset_we got %b want 1", we); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; wa_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the operand and result width, matching the register-file data width.
REQ-002 The block SHALL take parameter AW, default 4, as the destination-register address width.
REQ-003 The block SHALL have clock port clk, input, 1 bit; the only clock, rising-edge active.
REQ-004 The block SHALL have reset port reset, input, 1 bit; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit; a request to begin an operation.
REQ-006 The block SHALL have port op, input, 2 bits; 0=MUL (low byte), 1=MULH (high byte), 2=DIV (quotient), 3=REM (remainder).
REQ-007 The block SHALL have ports src_a and src_b, input, WIDTH each; operands taken from register-file outputs RD1 and RD2.
REQ-008 The block SHALL have port wa_in, input, AW bits; the destination register address.
REQ-009 The block SHALL have port busy, output, 1 bit; high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit; a one-cycle pulse when result is valid.
REQ-011 The block SHALL have port result, output, WIDTH; the value to write back.
REQ-012 The block SHALL have port wa_out, output, AW bits; the captured wa_in, aligned with result.
REQ-013 The block SHALL have port we_out, output, 1 bit; the register-file write enable, equal to done AND (wa_out != 0).

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE SHALL go to RUN on start; it SHALL latch op, src_a, src_b and wa_in, and clear the iteration counter.
REQ-016 RUN SHALL perform exactly WIDTH iterations, one per clock, and then go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1.
REQ-018 DONE SHALL go to RUN if start=1 in that cycle (back-to-back, operands latched); otherwise it SHALL go to IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from the start-sampling edge to done=1, i.e. 9 cycles at the default.
REQ-020 busy SHALL be 1 in RUN, and 0 in IDLE and DONE.
REQ-021 start while in RUN SHALL be ignored, with no effect on latched operands or progress.
REQ-022 MUL/MULH SHALL use unsigned shift-add into a 2*WIDTH-bit accumulator; MUL returns bits [WIDTH-1:0] and MULH returns bits [2*WIDTH-1:WIDTH].
REQ-023 DIV/REM SHALL use unsigned restoring division with a WIDTH+1-bit partial remainder; DIV returns the quotient and REM the remainder.
REQ-024 Divide by zero SHALL produce quotient all-ones (0xFF) and remainder = src_a, without trapping; latency is unchanged.
REQ-025 result and wa_out SHALL hold their last values until the next DONE, and SHALL be valid at least during done.
REQ-026 Operand inputs SHALL be don't-care outside the start-sampling cycle.
REQ-027 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 reset=1 SHALL, at the next rising edge, force state to IDLE and clear busy, done, we_out, result, wa_out, the counter and all datapath registers.
REQ-029 reset SHALL take priority over start.
REQ-030 reset asserted mid-RUN SHALL abort the operation with no done pulse and no write-back.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-032 Shared package muldiv_pkg SHALL hold the op enum (MUL, MULH, DIV, REM) and the state enum (IDLE, RUN, DONE).
REQ-033 The block SHALL be a single module with no sub-module; the multiply and divide datapaths share the counter and operand registers.
REQ-034 All state SHALL be in clocked processes; outputs SHALL be registered except we_out, which is combinational from registered done and wa_out.

Verification
REQ-035 MUL 13*11, wa_in=3 -> done at cycle 9 with result=0x8F, wa_out=3, we_out=1.
REQ-036 MULH 200*200 (0x9C40) -> result=0x9C; a repeated run with MUL -> result=0x40.
REQ-037 DIV 100/7 -> 0x0E; REM 100/7 -> 0x02; DIV 0x55/0 -> 0xFF; REM 0x55/0 -> 0x55.
REQ-038 start pulsed at cycles 3 and 5 of RUN with different operands -> first result unchanged and only one done.
REQ-039 start held high through DONE -> second op begins with no idle cycle, done pulses 9 cycles apart; wa_in=0 -> done=1, we_out=0.
REQ-040 reset at RUN cycle 4 -> busy=0 next cycle, no done, result=0; a new MUL 2*3 -> 0x06 at latency 9.
